// File: rtl/posit_pkg.sv
// Shared types for the posit unit: operation and rounding encodings plus the
// request record that travels from issue logic into the datapath.
package posit_pkg;

  localparam int unsigned POSIT_WIDTH = 32;
  localparam int unsigned POSIT_NUM_OPERANDS = 3;
  localparam int unsigned POSIT_TAG_WIDTH = 1;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  // Request record at the default widths, for consumers that want the bundle whole.
  typedef struct packed {
    logic [POSIT_NUM_OPERANDS-1:0][POSIT_WIDTH-1:0] operands;
    operation_e                                     op;
    logic                                           op_mod;
    roundmode_e                                     rnd_mode;
    logic [POSIT_TAG_WIDTH-1:0]                     tag;
  } posit_req_t;

endpackage

// File: rtl/posit_issue_queue_if.sv
// Valid/ready request bus into the issue queue and from its head to the datapath.
// The queue takes the slave side; the producer/consumer pair takes master.
interface posit_issue_queue_if #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned TAG_WIDTH    = 1
) ();
  import posit_pkg::*;

  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0]   operands_i;
  operation_e                           op_i;
  logic                                 op_mod_i;
  roundmode_e                           rnd_mode_i;
  logic [TAG_WIDTH-1:0]                 tag_i;

  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0]   operands_o;
  operation_e                           op_o;
  logic                                 op_mod_o;
  roundmode_e                           rnd_mode_o;
  logic [TAG_WIDTH-1:0]                 tag_o;

  modport slave (
    input  in_valid_i, operands_i, op_i, op_mod_i, rnd_mode_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, operands_o, op_o, op_mod_o, rnd_mode_o, tag_o
  );

  modport master (
    output in_valid_i, operands_i, op_i, op_mod_i, rnd_mode_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, operands_o, op_o, op_mod_o, rnd_mode_o, tag_o
  );

endinterface

// File: rtl/posit_issue_queue.sv
// Registered FIFO in front of the posit datapath: one-cycle latency, no
// fall-through, ready derived only from occupancy so out_ready never reaches in_ready.
module posit_issue_queue
  import posit_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TAG_WIDTH    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  posit_issue_queue_if.slave           bus,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] operands;
    operation_e                         op;
    logic                               op_mod;
    roundmode_e                         rnd_mode;
    logic [TAG_WIDTH-1:0]               tag;
  } entry_t;

  entry_t          store_q [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            in_ready;
  logic            out_valid;
  logic            push;
  logic            pop;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);

  // A flush swallows any handshake in the same cycle.
  assign push = bus.in_valid_i & in_ready & ~flush_i;
  assign pop  = out_valid & bus.out_ready_i & ~flush_i;

  assign in_entry.operands = bus.operands_i;
  assign in_entry.op       = bus.op_i;
  assign in_entry.op_mod   = bus.op_mod_i;
  assign in_entry.rnd_mode = bus.rnd_mode_i;
  assign in_entry.tag      = bus.tag_i;

  // Entry storage carries no reset; contents are only observed behind out_valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      store_q[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = store_q[rd_ptr];

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.operands_o  = head.operands;
  assign bus.op_o        = head.op;
  assign bus.op_mod_o    = head.op_mod;
  assign bus.rnd_mode_o  = head.rnd_mode;
  assign bus.tag_o       = head.tag;

  assign busy_o  = out_valid;
  assign count_o = count;

endmodule

// File: tb/tb_posit_issue_queue.sv
// Self-checking bench for posit_issue_queue: table vectors, hand-written corner
// sequences and a random phase, all against a queue-based reference model.
module tb_posit_issue_queue;
  import posit_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0][31:0] operands;
    operation_e       op;
    logic             op_mod;
    roundmode_e       rnd;
    logic             tag;
  } req_s;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    operation_e op;
    logic [2:0] exp_count;
    logic       exp_ov;
    logic       exp_ir;
    operation_e exp_op;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       busy_o;
  logic [2:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;
  req_s model[$];
  vec_t tbl[9];

  posit_issue_queue_if #(.WIDTH(32), .NUM_OPERANDS(3), .TAG_WIDTH(1)) bus ();

  posit_issue_queue #(.WIDTH(32), .NUM_OPERANDS(3), .DEPTH(DEPTH), .TAG_WIDTH(1)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus.slave),
    .busy_o  (busy_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_s rand_req();
    req_s r;
    r.operands[0] = $urandom;
    r.operands[1] = $urandom;
    r.operands[2] = $urandom;
    r.op          = operation_e'($urandom_range(0, 14));
    r.op_mod      = 1'($urandom_range(0, 1));
    r.rnd         = roundmode_e'($urandom_range(0, 4));
    r.tag         = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl, input req_s r);
    bus.in_valid_i  = iv;
    bus.out_ready_i = ordy;
    flush_i         = fl;
    bus.operands_i  = r.operands;
    bus.op_i        = r.op;
    bus.op_mod_i    = r.op_mod;
    bus.rnd_mode_i  = r.rnd;
    bus.tag_i       = r.tag;
  endtask

  task automatic check_head(input string name);
    if (model.size() > 0) begin
      check({name, "_operands"}, 128'(bus.operands_o), 128'(model[0].operands));
      check({name, "_op"},       128'(bus.op_o),       128'(model[0].op));
      check({name, "_op_mod"},   128'(bus.op_mod_o),   128'(model[0].op_mod));
      check({name, "_rnd"},      128'(bus.rnd_mode_o), 128'(model[0].rnd));
      check({name, "_tag"},      128'(bus.tag_o),      128'(model[0].tag));
    end
  endtask

  // Advances one clock with the currently driven inputs and checks the model.
  task automatic cycle(input string name);
    req_s r;
    bit   do_push;
    bit   do_pop;
    bit   do_flush;
    r.operands = bus.operands_i;
    r.op       = bus.op_i;
    r.op_mod   = bus.op_mod_i;
    r.rnd      = bus.rnd_mode_i;
    r.tag      = bus.tag_i;
    do_flush = (flush_i === 1'b1);
    do_push  = (bus.in_valid_i === 1'b1) && (model.size() < DEPTH) && !do_flush;
    do_pop   = (bus.out_ready_i === 1'b1) && (model.size() > 0) && !do_flush;
    @(posedge clk_i);
    #1;
    if (do_flush) model.delete();
    else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(r);
    end
    check({name, "_count"},     128'(count_o),         128'(model.size()));
    check({name, "_out_valid"}, 128'(bus.out_valid_o), 128'(model.size() != 0));
    check({name, "_in_ready"},  128'(bus.in_ready_o),  128'(model.size() < DEPTH));
    check({name, "_busy"},      128'(busy_o),          128'(model.size() != 0));
    check_head(name);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, rand_req());
      cycle("fill");
    end
  endtask

  initial begin
    req_s r;

    tbl[0] = '{1'b1, 1'b0, 1'b0, SGNJ,   3'd1, 1'b1, 1'b1, SGNJ};
    tbl[1] = '{1'b1, 1'b0, 1'b0, MINMAX, 3'd2, 1'b1, 1'b1, SGNJ};
    tbl[2] = '{1'b1, 1'b0, 1'b0, CMP,    3'd3, 1'b1, 1'b1, SGNJ};
    tbl[3] = '{1'b1, 1'b0, 1'b0, DIV,    3'd4, 1'b1, 1'b0, SGNJ};
    tbl[4] = '{1'b1, 1'b0, 1'b0, ADD,    3'd4, 1'b1, 1'b0, SGNJ};
    tbl[5] = '{1'b1, 1'b1, 1'b0, MUL,    3'd3, 1'b1, 1'b1, MINMAX};
    tbl[6] = '{1'b0, 1'b1, 1'b0, ADD,    3'd2, 1'b1, 1'b1, CMP};
    tbl[7] = '{1'b0, 1'b1, 1'b0, ADD,    3'd1, 1'b1, 1'b1, DIV};
    tbl[8] = '{1'b0, 1'b1, 1'b0, ADD,    3'd0, 1'b0, 1'b1, ADD};

    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 1'b0, rand_req());
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count",     128'(count_o),         128'(0));
    check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("rst_in_ready",  128'(bus.in_ready_o),  128'(1));
    check("rst_busy",      128'(busy_o),          128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single ADD request: visible the cycle after the push, never the same cycle.
    r.operands[0] = 32'h01C31BDF;
    r.operands[1] = 32'h01DDF3D1;
    r.operands[2] = 32'h0;
    r.op = ADD; r.op_mod = 1'b0; r.rnd = RNE; r.tag = 1'b1;
    drive(1'b1, 1'b0, 1'b0, r);
    #1;
    check("no_fallthrough", 128'(bus.out_valid_o), 128'(0));
    cycle("add_push");
    check("add_count",    128'(count_o),        128'(1));
    check("add_operands", 128'(bus.operands_o), {32'h0, 32'h0, 32'h01DDF3D1, 32'h01C31BDF});
    check("add_tag",      128'(bus.tag_o),      128'(1));
    drive(1'b0, 1'b1, 1'b0, rand_req());
    cycle("add_pop");

    // Fill to full with the 5th push ignored, push+pop while full, then drain.
    for (int i = 0; i < 9; i++) begin
      r = rand_req();
      r.op = tbl[i].op;
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, r);
      cycle("tbl");
      check($sformatf("tbl%0d_count", i), 128'(count_o),         128'(tbl[i].exp_count));
      check($sformatf("tbl%0d_ov", i),    128'(bus.out_valid_o), 128'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_ir", i),    128'(bus.in_ready_o),  128'(tbl[i].exp_ir));
      if (tbl[i].exp_ov) check($sformatf("tbl%0d_op", i), 128'(bus.op_o), 128'(tbl[i].exp_op));
    end

    // Steady push+pop at occupancy 2 walks the pointers round the ring.
    fill(2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, rand_req());
      cycle("stream");
      check("stream_count2", 128'(count_o), 128'(2));
    end
    drive(1'b0, 1'b1, 1'b0, rand_req());
    cycle("stream_drain");
    cycle("stream_drain");

    // Flush with a coincident push at occupancy 3.
    fill(3);
    drive(1'b1, 1'b1, 1'b1, rand_req());
    cycle("flush");
    check("flush_count", 128'(count_o),         128'(0));
    check("flush_ov",    128'(bus.out_valid_o), 128'(0));
    check("flush_ir",    128'(bus.in_ready_o),  128'(1));
    drive(1'b0, 1'b0, 1'b0, rand_req());
    cycle("post_flush");
    check("flush_absent", 128'(bus.out_valid_o), 128'(0));

    // Asynchronous reset between clock edges with two entries queued.
    fill(2);
    drive(1'b0, 1'b0, 1'b0, rand_req());
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_count", 128'(count_o),         128'(0));
    check("async_rst_ov",    128'(bus.out_valid_o), 128'(0));
    check("async_rst_busy",  128'(busy_o),          128'(0));
    check("async_rst_ir",    128'(bus.in_ready_o),  128'(1));
    model.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    drive(1'b1, 1'b0, 1'b0, rand_req());
    cycle("after_rst");
    check("after_rst_count", 128'(count_o), 128'(1));

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), rand_req());
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_issue_queue.md
POSIT_ISSUE_QUEUE -- requirements
Module: posit_issue_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, posit operand width in bits.
REQ-002 SHALL have parameter NUM_OPERANDS, default 3, operands per request.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 SHALL have parameter TAG_WIDTH, default 1, width of the opaque request tag.
REQ-005 SHALL have ports: clk_i  in  1  clock, rising edge; rst_ni  in  1  reset.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports: flush_i  in  1  synchronous queue clear; in_valid_i  in  1; in_ready_o  out  1.
REQ-008 SHALL have ports: operands_i  in  NUM_OPERANDS x WIDTH; op_i  in  posit_pkg::operation_e; op_mod_i  in  1; rnd_mode_i  in  posit_pkg::roundmode_e; tag_i  in  TAG_WIDTH.
REQ-009 SHALL have ports: out_valid_o  out  1; out_ready_i  in  1; operands_o, op_o, op_mod_o, rnd_mode_o, tag_o  out  same types as inputs.
REQ-010 SHALL have ports: busy_o  out  1  queue non-empty; count_o  out  $clog2(DEPTH+1)  occupancy.

Function
REQ-011 SHALL accept a request when in_valid_i and in_ready_o are both high at a rising edge (push).
REQ-012 SHALL deliver a request when out_valid_o and out_ready_i are both high at a rising edge (pop).
REQ-013 SHALL drive in_ready_o = (count < DEPTH), from registered state only, with no combinational path from out_ready_i.
REQ-014 SHALL drive out_valid_o = (count != 0), with outputs taken from the head entry.
REQ-015 SHALL have latency of one cycle: a request pushed into an empty queue appears on out_valid_o the next cycle, with no fall-through.
REQ-016 SHALL preserve strict FIFO order; all fields of an entry travel together unmodified.
REQ-017 SHALL perform push and pop in the same cycle when both handshakes fire, leaving count unchanged.
REQ-018 SHALL hold in_ready_o low when full, even if a pop occurs that cycle; the freed slot is usable from the next cycle.
REQ-019 SHALL wrap read and write pointers modulo DEPTH.
REQ-020 SHALL, on flush_i high at a rising edge, set count and both pointers to 0.
REQ-021 SHALL discard any push or pop coinciding with flush_i.
REQ-022 SHALL hold head outputs stable while out_valid_o is high and out_ready_i is low.
REQ-023 SHALL drive busy_o = out_valid_o.
REQ-024 SHALL drive count_o from a registered counter that never exceeds DEPTH or underflows.
REQ-025 SHALL ignore in_valid_i when in_ready_o is low, with no state change and no error.

Reset
REQ-026 SHALL, while rst_ni is low, immediately force count to 0, both pointers to 0, out_valid_o to 0, busy_o to 0, count_o to 0 and in_ready_o to 1.
REQ-027 SHALL treat entry storage contents as don't-care after reset; head data outputs are undefined while out_valid_o is 0.
REQ-028 SHALL, when reset asserts mid-operation, lose all queued requests; the first push after release behaves as into an empty queue.

Structure
REQ-029 SHALL take operation_e and roundmode_e from posit_pkg.
REQ-030 SHALL have posit_pkg add the packed struct posit_req_t (operands, op, op_mod, rnd_mode, tag) for use by this block and its consumers.
REQ-031 SHALL keep storage and pointer logic inline; no sub-module is required.

Verification
REQ-032 Bench SHALL cover: reset, then push ADD with operands {0x01C31BDF, 0x01DDF3D1, 0}, tag 1 -> out_valid_o high next cycle, same fields on outputs, count_o = 1.
REQ-033 Bench SHALL cover: out_ready_i = 0, push DEPTH = 4 requests (SGNJ, MINMAX, CMP, DIV) -> in_ready_o low after 4th push, count_o = 4, a 5th push ignored; then drain -> outputs in order SGNJ, MINMAX, CMP, DIV.
REQ-034 Bench SHALL cover: full queue with push and pop in the same cycle -> pop succeeds, push rejected, count_o = 3 next cycle.
REQ-035 Bench SHALL cover: count_o = 2 with simultaneous push and pop every cycle for 10 cycles -> count_o stays 2, pointers wrap, order preserved.
REQ-036 Bench SHALL cover: count_o = 3 with flush_i and in_valid_i high together -> next cycle count_o = 0, out_valid_o = 0, in_ready_o = 1, pushed request absent.
REQ-037 Bench SHALL cover: rst_ni pulsed low mid-clock with count_o = 2 -> count_o, out_valid_o and busy_o go to 0 without waiting for a clock edge.
